dma_engine: RTL

Parametrised multi-channel DMA engine, successor to the single-channel DMA controller in the SoC. It moves 32-bit words from SRAM to a destination address (SRAM or a peripheral data register) on behalf of `NUM_CH` peripheral request lines. Arbitration between channels is round-robin, one word per grant. It sits between the interconnect config path and the on-chip SRAM port.

---
 rtl/dma_engine.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_engine
// Description : Multi-channel SRAM-to-SRAM/peripheral DMA engine. NUM_CH
//               request lines share one memory port; round-robin
//               arbitration, one 32-bit word per grant, 4 cycles per word
//               (IDLE arbitration, READ, WAIT, WRITE).
// Options     : DMA_ENGINE_DST_HOLD_EN - per-channel dst_hold flag (ctrl
//               bit1) that keeps the destination address fixed.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_engine #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  input  logic [NUM_CH-1:0] dma_request,
  output logic [NUM_CH-1:0] dma_ack,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] ch_armed,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam logic [1:0] C_SEL_SRC  = 2'd0;
  localparam logic [1:0] C_SEL_DST  = 2'd1;
  localparam logic [1:0] C_SEL_LEN  = 2'd2;
  localparam logic [1:0] C_SEL_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_src [NUM_CH];
  logic [ADDR_W-1:0] r_dst [NUM_CH];
  logic [LEN_W-1:0]  r_len [NUM_CH];
  logic [NUM_CH-1:0] r_armed;
  logic [NUM_CH-1:0] r_abort_pend;   // abort requested while channel is in flight
  logic [NUM_CH-1:0] r_zero_done;    // done pulse for an arm attempt with len = 0
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_data;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_cfg_hit;
  logic [NUM_CH-1:0] w_ctrl_hit;
  logic [NUM_CH-1:0] w_wr_done;
  logic [CH_W-1:0]   w_pick;
  logic              w_found;
  logic              w_last;
  logic              w_abort_g;
  logic              w_hold_g;

  // Decode of the config target; out-of-range channel numbers match nothing
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cfg_hit
      assign w_cfg_hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));
    end
  endgenerate

  assign w_ctrl_hit = w_cfg_hit & {NUM_CH{cfg_sel == C_SEL_CTRL}};
  assign w_elig     = r_armed & dma_request;
  assign w_last     = (r_len[r_grant] == LEN_W'(1));
  // Abort on the granted channel, either latched earlier or arriving now
  assign w_abort_g  = r_abort_pend[r_grant] | (w_ctrl_hit[r_grant] & ~cfg_wdata[0]);
  assign ch_armed   = r_armed;
  assign done       = w_wr_done | r_zero_done;

`ifdef DMA_ENGINE_DST_HOLD_EN
  logic [NUM_CH-1:0] r_hold;

  // Per-channel dst_hold flag, stored on every ctrl write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ctrl_hit[i]) r_hold[i] <= cfg_wdata[1];
      end
    end
  end

  assign w_hold_g = r_hold[r_grant];
`else
  assign w_hold_g = 1'b0;
`endif

  // Round-robin pick: first eligible channel at or above rr_ptr, with wrap
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    // Walk from the farthest offset down so the nearest eligible one wins
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_CH;
      if (w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(idx);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and memory-port outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    dma_ack     = '0;
    w_wr_done   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_READ;
      end
      S_READ: begin
        mem_rd_en   = 1'b1;
        mem_addr    = r_src[r_grant];
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en        = 1'b1;
        mem_addr         = r_dst[r_grant];
        mem_wr_data      = r_data;
        dma_ack[r_grant] = 1'b1;
        // An aborted channel finishes its word silently
        if (w_last && !w_abort_g) w_wr_done[r_grant] = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Channel registers, grant, arbitration pointer and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
        r_len[i] <= '0;
      end
      r_armed      <= '0;
      r_abort_pend <= '0;
      r_zero_done  <= '0;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_data       <= '0;
    end else begin
      r_zero_done <= '0;
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (r_state == S_WAIT) r_data <= mem_rd_data;

      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfg_hit[i]) begin
          case (cfg_sel)
            C_SEL_SRC: if (!r_armed[i]) r_src[i] <= ADDR_W'(cfg_wdata);
            C_SEL_DST: if (!r_armed[i]) r_dst[i] <= ADDR_W'(cfg_wdata);
            C_SEL_LEN: if (!r_armed[i]) r_len[i] <= LEN_W'(cfg_wdata);
            default: begin
              if (cfg_wdata[0]) begin
                r_abort_pend[i] <= 1'b0;
                if (!r_armed[i]) begin
                  if (r_len[i] == '0) r_zero_done[i] <= 1'b1;
                  else                r_armed[i]     <= 1'b1;
                end
              end else if (r_state != S_IDLE && r_grant == CH_W'(i)) begin
                // In flight: let the word finish, disarm at the write
                r_abort_pend[i] <= 1'b1;
              end else begin
                r_armed[i] <= 1'b0;
              end
            end
          endcase
        end
      end

      // Word completion overrides any same-cycle config effect on the channel
      if (r_state == S_WRITE) begin
        r_src[r_grant] <= r_src[r_grant] + ADDR_W'(1);
        if (!w_hold_g) r_dst[r_grant] <= r_dst[r_grant] + ADDR_W'(1);
        if (r_len[r_grant] != '0) r_len[r_grant] <= r_len[r_grant] - LEN_W'(1);
        r_rr_ptr <= CH_W'((int'(r_grant) + 1) % NUM_CH);
        r_abort_pend[r_grant] <= 1'b0;
        if (w_last || w_abort_g) r_armed[r_grant] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
